pwm_capture: RTL
================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter WIDTH, default 16: width of the period and high-time counters and result outputs.
REQ-002 Parameter SYNC_STAGES, default 2 (minimum 2): number of synchronizer flops on pwm_in.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 pwm_in  input  1  PWM waveform under measurement; asynchronous to clk.
REQ-006 clr  input  1  synchronous clear of results, sticky flags and FSM.
REQ-007 period  output  WIDTH  clk cycles between the last two rising edges.
REQ-008 high_time  output  WIDTH  clk cycles from the last completed rise to its fall.
REQ-009 valid  output  1  one-cycle pulse when period/high_time are updated.
REQ-010 locked  output  1  at least one complete measurement captured since reset/clr.
REQ-011 ovf  output  1  sticky; the counter saturated without a rise.

Function
REQ-012 pwm_in shall pass through SYNC_STAGES flops; rise/fall events shall come from the synchronized (optionally filtered) signal versus its one-cycle-delayed copy.
REQ-013 FSM states: SEEK (wait for first rise), HIGH (count high phase), LOW (count low phase).
REQ-014 SEEK: a rise moves the FSM to HIGH and loads cnt=1; falls are ignored.
REQ-015 HIGH: cnt increments each cycle; a fall latches hi_lat=cnt and moves the FSM to LOW.
REQ-016 LOW: cnt increments; a rise sets period=cnt, high_time=hi_lat, valid=1 for one cycle, locked=1, then cnt=1 and the FSM moves to HIGH.
REQ-017 Latency: valid shall be high in the cycle after the (SYNC_STAGES+1)th posedge following the first posedge that samples pwm_in high.
REQ-018 Saturation: if cnt reaches 2^WIDTH-1 in HIGH or LOW, ovf is set, the FSM goes to SEEK, no valid is produced, and period/high_time hold their previous values.
REQ-019 A constant-high or constant-low pwm_in shall therefore produce ovf after at most 2^WIDTH-1 cycles in HIGH/LOW; in SEEK, ovf shall never be set.
REQ-020 clr shall win over any same-cycle event: FSM to SEEK, cnt/hi_lat/period/high_time to 0, valid/locked/ovf to 0.
REQ-021 period and high_time shall change only in the valid cycle or on clr/reset.
REQ-022 Every measurement shall satisfy 1 <= high_time < period.

Reset
REQ-023 Asserting rst_n low shall immediately set: FSM to SEEK, synchronizer/filter flops to 0, cnt, hi_lat, period and high_time to 0, valid, locked and ovf to 0.
REQ-024 Reset asserted mid-measurement shall discard the partial measurement; after release, measurement restarts with the next rise.

Configuration
REQ-025 Macro PWM_CAPTURE_GLITCH_FILTER_EN:
- Defined: the synchronized signal changes only after 3 consecutive identical samples; latency in REQ-017 grows by 2 cycles; pulses of 1-2 cycles are suppressed.
- Undefined: the synchronized signal is used directly.

Structure
REQ-026 Package pwm_pkg shall hold PWM_WIDTH=16 (the WIDTH default) and the FSM state enum typedef (SEEK, HIGH, LOW).
REQ-027 Sub-module pwm_edge_sync shall contain the synchronizer, the optional filter and rise/fall detection; pwm_capture shall contain the FSM, counters and result registers.

Verification
REQ-028 Bench drives pwm_in from a PWM generator with top=9, cmp=3 -> after the second rise: valid pulses every 10 cycles, period=10, high_time=3, locked=1.
REQ-029 Reprogram the generator to top=99, cmp=50 mid-run -> first full new period reports period=100, high_time=50; no valid carries mixed values.
REQ-030 Hold pwm_in high (cmp>top), WIDTH=8 -> ovf=1 within 255 cycles of the rise; FSM in SEEK; no valid.
REQ-031 Assert clr in the same cycle as a rise event -> no valid; period=0, high_time=0, locked=0; the next full period is measured correctly.
REQ-032 Pulse rst_n low mid-HIGH phase -> all outputs 0 immediately; the first valid arrives after two rises post-release.
REQ-033 With PWM_CAPTURE_GLITCH_FILTER_EN, inject 1-cycle low glitches into a top=19, cmp=10 waveform -> period=20, high_time=10 unchanged; latency +2 cycles versus the build without the macro.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture block: default counter width and FSM state encoding.
package pwm_pkg;

  localparam int PWM_WIDTH = 16;

  typedef enum logic [1:0] {
    SEEK = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchronizes pwm_in, optionally filters it (PWM_CAPTURE_GLITCH_FILTER_EN), and emits
// registered one-cycle rise/fall events.
module pwm_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig;
  logic                   sig_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic [1:0] hist;
  logic       filt_q;

  // Output follows the input only once three consecutive samples agree.
  assign sig = ((sync_q[SYNC_STAGES-1] == hist[0]) && (hist[0] == hist[1]))
               ? sync_q[SYNC_STAGES-1] : filt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist   <= '0;
      filt_q <= 1'b0;
    end else begin
      hist   <= {hist[0], sync_q[SYNC_STAGES-1]};
      filt_q <= sig;
    end
  end
`else
  assign sig = sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_d <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sig_d <= sig;
      rise  <= sig & ~sig_d;
      fall  <= ~sig & sig_d;
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// PWM period / high-time capture: SEEK/HIGH/LOW FSM with saturating counter.
// Optional input glitch filter in pwm_edge_sync via PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int WIDTH       = PWM_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  input  logic             clr,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             rise;
  logic             fall;
  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] hi_lat;

  pwm_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .pwm_in(pwm_in),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEEK;
      cnt       <= '0;
      hi_lat    <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (clr) begin
        state     <= SEEK;
        cnt       <= '0;
        hi_lat    <= '0;
        period    <= '0;
        high_time <= '0;
        locked    <= 1'b0;
        ovf       <= 1'b0;
      end else begin
        case (state)
          SEEK: begin
            if (rise) begin
              cnt   <= CNT_ONE;
              state <= HIGH;
            end
          end
          HIGH: begin
            // Saturating here keeps hi_lat strictly below any later period.
            if (cnt == CNT_MAX) begin
              ovf   <= 1'b1;
              state <= SEEK;
            end else begin
              cnt <= cnt + CNT_ONE;
              if (fall) begin
                hi_lat <= cnt;
                state  <= LOW;
              end
            end
          end
          LOW: begin
            if (rise) begin
              period    <= cnt;
              high_time <= hi_lat;
              valid     <= 1'b1;
              locked    <= 1'b1;
              cnt       <= CNT_ONE;
              state     <= HIGH;
            end else if (cnt == CNT_MAX) begin
              ovf   <= 1'b1;
              state <= SEEK;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: state <= SEEK;
        endcase
      end
    end
  end

endmodule
